// File: rtl/hough_peak_reader.sv
// Scans the Hough accumulator RAM. Cells at or above THRESHOLD go out through a 2-deep ready/valid FIFO.
// The block also tracks the maximum cell and can zero each cell after it is read.
module hough_peak_reader #(
  parameter int N_RHO         = 2048,
  parameter int N_THETA       = 180,
  parameter int VOTE_W        = 16,
  parameter int THRESHOLD     = 100,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              rd_enable,
  output logic [10:0]       rd_address,
  output logic [7:0]        rd_theta,
  input  logic [VOTE_W-1:0] rd_data,
  output logic              clr_wren,
  output logic [10:0]       clr_address,
  output logic [7:0]        clr_theta,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [10:0]       peak_rho,
  output logic [7:0]        peak_theta,
  output logic [VOTE_W-1:0] peak_votes,
  output logic              busy,
  output logic              done,
  output logic [10:0]       max_rho,
  output logic [7:0]        max_theta,
  output logic [VOTE_W-1:0] max_votes
);
  localparam int RHO_W   = 11;
  localparam int THETA_W = 8;
  localparam logic [RHO_W-1:0]   LAST_RHO   = RHO_W'(N_RHO - 1);
  localparam logic [THETA_W-1:0] LAST_THETA = THETA_W'(N_THETA - 1);
  localparam logic [VOTE_W-1:0]  THRESH     = VOTE_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [RHO_W-1:0]   rho;
    logic [THETA_W-1:0] theta;
    logic [VOTE_W-1:0]  votes;
  } peak_t;

  state_t             state;
  logic [RHO_W-1:0]   rho_cnt;
  logic [THETA_W-1:0] theta_cnt;
  logic               pending;
  logic [RHO_W-1:0]   ev_rho;
  logic [THETA_W-1:0] ev_theta;
  peak_t              fifo0;
  peak_t              fifo1;
  logic [1:0]         fifo_count;

  logic               push;
  logic               pop;
  logic               issue;
  logic               last_cell;
  logic [1:0]         count_next;
  peak_t              new_entry;

  // The issue decision uses next-cycle FIFO occupancy and in-flight reads, so the strobe can be registered.
  always_comb begin
    push            = pending && (rd_data >= THRESH);
    pop             = (fifo_count != 2'd0) && peak_ready;
    count_next      = fifo_count + {1'b0, push} - {1'b0, pop};
    new_entry.rho   = ev_rho;
    new_entry.theta = ev_theta;
    new_entry.votes = rd_data;
    last_cell       = (rho_cnt == LAST_RHO) && (theta_cnt == LAST_THETA);
    if (state == SCAN) begin
      issue = (count_next + {1'b0, rd_enable}) <= 2'd1;
    end else begin
      issue = 1'b0;
    end
  end

  assign clr_wren    = CLEAR_ON_READ ? pending : 1'b0;
  assign clr_address = ev_rho;
  assign clr_theta   = ev_theta;
  assign peak_valid  = (fifo_count != 2'd0);
  assign peak_rho    = fifo0.rho;
  assign peak_theta  = fifo0.theta;
  assign peak_votes  = fifo0.votes;

  // Scan control, read pipeline, output FIFO and maximum tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rho_cnt    <= '0;
      theta_cnt  <= '0;
      pending    <= 1'b0;
      ev_rho     <= '0;
      ev_theta   <= '0;
      rd_enable  <= 1'b0;
      rd_address <= '0;
      rd_theta   <= '0;
      fifo0      <= '0;
      fifo1      <= '0;
      fifo_count <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_rho    <= '0;
      max_theta  <= '0;
      max_votes  <= '0;
    end else begin
      pending    <= rd_enable;
      ev_rho     <= rd_address;
      ev_theta   <= rd_theta;
      rd_enable  <= issue;
      fifo_count <= count_next;

      if (issue) begin
        rd_address <= rho_cnt;
        rd_theta   <= theta_cnt;
        if (last_cell) begin
          rho_cnt <= rho_cnt;
        end else if (rho_cnt == LAST_RHO) begin
          rho_cnt   <= '0;
          theta_cnt <= theta_cnt + 8'd1;
        end else begin
          rho_cnt <= rho_cnt + 11'd1;
        end
      end

      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) fifo0 <= new_entry;
          else                    fifo1 <= new_entry;
        end
        2'b01: fifo0 <= fifo1;
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo0 <= new_entry;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= new_entry;
          end
        end
        default: ;
      endcase

      // Strict compare keeps the earliest cell on ties
      if (pending && (rd_data > max_votes)) begin
        max_rho   <= ev_rho;
        max_theta <= ev_theta;
        max_votes <= rd_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            rho_cnt   <= '0;
            theta_cnt <= '0;
            max_rho   <= '0;
            max_theta <= '0;
            max_votes <= '0;
          end
        end
        SCAN: begin
          if (issue && last_cell) state <= DRAIN;
        end
        DRAIN: begin
          if (!rd_enable && !pending && (fifo_count == 2'd0)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hough_peak_reader.sv
// Directed bench for hough_peak_reader with N_RHO=8, N_THETA=4, THRESHOLD=3 and a behavioural accumulator RAM.
module tb_hough_peak_reader;
  logic        clock;
  logic        reset;
  logic        start;
  logic        rd_enable;
  logic [10:0] rd_address;
  logic [7:0]  rd_theta;
  logic [15:0] rd_data;
  logic        clr_wren;
  logic [10:0] clr_address;
  logic [7:0]  clr_theta;
  logic        peak_valid;
  logic        peak_ready;
  logic [10:0] peak_rho;
  logic [7:0]  peak_theta;
  logic [15:0] peak_votes;
  logic        busy;
  logic        done;
  logic [10:0] max_rho;
  logic [7:0]  max_theta;
  logic [15:0] max_votes;

  hough_peak_reader #(
    .N_RHO(8), .N_THETA(4), .VOTE_W(16), .THRESHOLD(3), .CLEAR_ON_READ(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .rd_enable(rd_enable), .rd_address(rd_address), .rd_theta(rd_theta), .rd_data(rd_data),
    .clr_wren(clr_wren), .clr_address(clr_address), .clr_theta(clr_theta),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_rho(peak_rho),
    .peak_theta(peak_theta), .peak_votes(peak_votes), .busy(busy), .done(done),
    .max_rho(max_rho), .max_theta(max_theta), .max_votes(max_votes)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:31];
  logic [15:0] init_mem [0:31];
  logic        load;

  int rd_count = 0;
  int clr_count = 0;
  int done_count = 0;
  int done_early = 0;
  int stall_bad = 0;
  logic        stalled_prev = 1'b0;
  logic [34:0] held = '0;
  logic [34:0] pk_q [$];

  int ready_mode = 0;
  int phase = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accumulator RAM: 1-cycle read latency, clear port, bulk preload
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else if (clr_wren) begin
      mem[{clr_theta[1:0], clr_address[2:0]}] <= 16'd0;
    end
    if (rd_enable) rd_data <= mem[{rd_theta[1:0], rd_address[2:0]}];
  end

  // Output monitor sampled mid-cycle
  always @(negedge clock) begin
    if (rd_enable) rd_count <= rd_count + 1;
    if (clr_wren) clr_count <= clr_count + 1;
    if (done) begin
      done_count <= done_count + 1;
      if (peak_valid) done_early <= done_early + 1;
    end
    if (peak_valid && peak_ready) pk_q.push_back({peak_rho, peak_theta, peak_votes});
    if (stalled_prev && (!peak_valid || ({peak_rho, peak_theta, peak_votes} !== held)))
      stall_bad <= stall_bad + 1;
    stalled_prev <= peak_valid && !peak_ready;
    held <= {peak_rho, peak_theta, peak_votes};
  end

  initial begin
    peak_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      phase++;
      case (ready_mode)
        0:       peak_ready = 1'b1;
        1:       peak_ready = 1'b0;
        default: peak_ready = (phase % 4 == 0);
      endcase
    end
  end

  task automatic load_ram();
    @(posedge clock); #1 load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 32; i++) init_mem[i] = v;
  endtask

  function automatic int nonzero_cells();
    int n = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 16'd0) n++;
    return n;
  endfunction

  task automatic start_scan();
    @(posedge clock); #1 start = 1'b1;
    @(negedge clock);
    check("busy_before", {63'd0, busy}, 64'd0);
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int extra_start);
    bit seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (n == extra_start);
    end
    start = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) check("busy_fall", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int rd_base, clr_base, done_base, pk_base, bad, snap_rd, snap_clr;
    reset = 1'b1;
    start = 1'b0;
    load = 1'b0;
    set_all(16'd0);
    repeat (3) @(negedge clock);
    check("rst_rd_enable", {63'd0, rd_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_peak_valid", {63'd0, peak_valid}, 64'd0);
    check("rst_max_votes", {48'd0, max_votes}, 64'd0);
    reset = 1'b0;
    load_ram();

    // 1: empty RAM
    rd_base = rd_count; done_base = done_count; pk_base = pk_q.size();
    start_scan();
    wait_done(-1);
    check("t1_reads", rd_count - rd_base, 32);
    check("t1_done_count", done_count - done_base, 1);
    check("t1_peaks", pk_q.size() - pk_base, 0);
    check("t1_max_votes", {48'd0, max_votes}, 64'd0);
    check("t1_max_rho", {53'd0, max_rho}, 64'd0);
    check("t1_max_theta", {56'd0, max_theta}, 64'd0);

    // 2: two hits, one sub-threshold cell, clear-on-read
    set_all(16'd0);
    init_mem[1*8+2] = 16'd5;
    init_mem[3*8+7] = 16'd3;
    init_mem[2*8+4] = 16'd2;
    load_ram();
    pk_base = pk_q.size(); clr_base = clr_count;
    start_scan();
    wait_done(-1);
    check("t2_peaks", pk_q.size() - pk_base, 2);
    if (pk_q.size() - pk_base == 2) begin
      check("t2_peak0", {29'd0, pk_q[pk_base]},     {29'd0, 11'd2, 8'd1, 16'd5});
      check("t2_peak1", {29'd0, pk_q[pk_base + 1]}, {29'd0, 11'd7, 8'd3, 16'd3});
    end
    check("t2_max_rho", {53'd0, max_rho}, 64'd2);
    check("t2_max_theta", {56'd0, max_theta}, 64'd1);
    check("t2_max_votes", {48'd0, max_votes}, 64'd5);
    check("t2_clears", clr_count - clr_base, 32);
    check("t2_ram_clean", nonzero_cells(), 0);

    // 3: tie keeps the earliest cell
    set_all(16'd0);
    init_mem[0*8+1] = 16'd9;
    init_mem[2*8+0] = 16'd9;
    load_ram();
    start_scan();
    wait_done(-1);
    check("t3_max_rho", {53'd0, max_rho}, 64'd1);
    check("t3_max_theta", {56'd0, max_theta}, 64'd0);
    check("t3_max_votes", {48'd0, max_votes}, 64'd9);

    // 4: all cells hit, consumer stalled then throttled
    set_all(16'd4);
    load_ram();
    rd_base = rd_count; pk_base = pk_q.size();
    ready_mode = 1;
    start_scan();
    repeat (20) @(negedge clock);
    check("t4_stall_reads", rd_count - rd_base, 2);
    check("t4_stall_valid", {63'd0, peak_valid}, 64'd1);
    ready_mode = 2;
    wait_done(-1);
    ready_mode = 0;
    check("t4_reads", rd_count - rd_base, 32);
    check("t4_peaks", pk_q.size() - pk_base, 32);
    bad = 0;
    if (pk_q.size() - pk_base == 32) begin
      for (int i = 0; i < 32; i++)
        if (pk_q[pk_base + i] !== {11'(i % 8), 8'(i / 8), 16'd4}) bad++;
    end
    check("t4_order_bad", bad, 0);
    check("t4_stall_stable", stall_bad, 0);
    check("t4_done_fifo_empty", done_early, 0);

    // 5: start during SCAN is ignored
    set_all(16'd0);
    init_mem[3*8+0] = 16'd7;
    load_ram();
    rd_base = rd_count; done_base = done_count;
    start_scan();
    wait_done(5);
    repeat (10) @(negedge clock);
    check("t5_reads", rd_count - rd_base, 32);
    check("t5_done_count", done_count - done_base, 1);
    check("t5_max_rho", {53'd0, max_rho}, 64'd0);
    check("t5_max_theta", {56'd0, max_theta}, 64'd3);
    check("t5_max_votes", {48'd0, max_votes}, 64'd7);

    // 6: reset at read 10 aborts the scan
    set_all(16'd6);
    load_ram();
    rd_base = rd_count;
    start_scan();
    for (int n = 0; n < 200 && (rd_count - rd_base) < 10; n++) @(negedge clock);
    reset = 1'b1;
    #1;
    check("t6_rd_enable", {63'd0, rd_enable}, 64'd0);
    check("t6_clr_wren", {63'd0, clr_wren}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_peak_valid", {63'd0, peak_valid}, 64'd0);
    check("t6_max_votes", {48'd0, max_votes}, 64'd0);
    @(negedge clock);
    @(posedge clock); #1;
    snap_rd = rd_count; snap_clr = clr_count;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    @(posedge clock); #1;
    check("t6_no_reads", rd_count - snap_rd, 0);
    check("t6_no_clears", clr_count - snap_clr, 0);
    rd_base = rd_count;
    start_scan();
    wait_done(-1);
    check("t6_rescan_reads", rd_count - rd_base, 32);
    check("t6_ram_clean", nonzero_cells(), 0);
    check("t6_max_votes_after", {48'd0, max_votes}, 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hough_peak_reader.md
# hough_peak_reader

Read-side counterpart of the Hough voting FSM. Once a frame's votes are accumulated in the dual-port accumulator RAM, this block scans every (theta, rho) cell and streams cells with `votes >= THRESHOLD` through a ready/valid interface. It also tracks the global maximum cell and, optionally, writes zero back to each cell so the RAM is clean for the next frame. It sits between the accumulator RAM's second port and the line-extraction logic.

## Interface
- `N_RHO`, 2048: rho cells per theta row; rho index width 11 bits.
- `N_THETA`, 180: theta rows; theta index width 8 bits.
- `VOTE_W`, 16: accumulator cell width.
- `THRESHOLD`, 100: minimum vote count for a cell to be reported.
- `CLEAR_ON_READ`, 1: when 1, zero each cell after it is read.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse; starts a scan; ignored unless idle.
- `rd_enable`  out  1  RAM read strobe.
- `rd_address`  out  11  rho index of the read.
- `rd_theta`  out  8  theta index of the read.
- `rd_data`  in  VOTE_W  RAM read data, valid exactly 1 cycle after `rd_enable`.
- `clr_wren`  out  1  RAM write strobe for the clear write.
- `clr_address`  out  11  rho index of the clear write.
- `clr_theta`  out  8  theta index of the clear write.
- `peak_valid`  out  1  output FIFO head is valid.
- `peak_ready`  in  1  consumer accepts the head.
- `peak_rho`  out  11  rho of the head.
- `peak_theta`  out  8  theta of the head.
- `peak_votes`  out  VOTE_W  votes of the head.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `max_rho`  out  11  rho of the maximum cell of the last scan.
- `max_theta`  out  8  theta of the maximum cell of the last scan.
- `max_votes`  out  VOTE_W  vote count of the maximum cell of the last scan.

## Operation
- States are IDLE, SCAN, DRAIN and DONE.
- **IDLE:** on `start`, zero the scan counters and the max registers, then go to SCAN.
- **SCAN order:** theta is the outer loop (0..N_THETA-1) and rho is the inner loop (0..N_RHO-1). One read is issued per cycle when allowed.
- **Issue rule:** a read is issued only when `fifo_count + pending <= 1`. `pending` = a read was issued last cycle. The output FIFO is 2 deep, so it can never overflow.
- **Evaluate:** one cycle after each read, compare `rd_data` with THRESHOLD.
  - If `rd_data >= THRESHOLD`, push {rho, theta, votes} into the FIFO.
  - If `rd_data > max_votes` (strict), update the max registers. Ties keep the earliest cell in scan order.
- **Clear:** when CLEAR_ON_READ=1, assert `clr_wren` for the evaluated cell in that same evaluate cycle, with the same address and theta. A read and a clear write may occur in the same cycle on different cells.
- **End of scan:** after the read of (N_THETA-1, N_RHO-1) is issued, go to DRAIN.
  - DRAIN waits for the last evaluation and for the FIFO to be empty.
  - DONE asserts `done` for 1 cycle, then returns to IDLE. `max_*` hold their values until the next accepted `start`.
- **FIFO:** push and pop in the same cycle are allowed. `peak_*` are don't-care while `peak_valid` = 0, but must hold stable while `peak_valid && !peak_ready`.
- **Reset:** clears the state to IDLE and empties the FIFO. All outputs are 0, including `max_*`. An aborted scan issues no further reads or clears. Reset mid-scan leaves partially cleared RAM; this is accepted.
- **Counters:** the rho counter wraps to 0 when theta increments. There is no wrap past the last theta.

## Timing
- Read latency is exactly 1 cycle.
- Scan time with `peak_ready` held at 1 is N_THETA*N_RHO read cycles.
- `busy` rises 1 cycle after `start`.
- `done` comes at least 2 cycles after the last read is issued.
- `busy` falls in the same cycle `done` pulses.
- `peak_valid` rises 1 cycle after the evaluate cycle of a hit.
- With `peak_ready` held at 0, reads stop with at most 2 entries buffered, and resume the cycle after a pop makes the issue rule true.

## Test plan
Use N_RHO=8, N_THETA=4, THRESHOLD=3 unless stated.
1. Empty RAM, `start`, `peak_ready`=1 -> `peak_valid` never asserts; exactly 32 `rd_enable` cycles; `done` once; `max_votes`=0, `max_rho`=0, `max_theta`=0.
2. Cells (t1,r2)=5, (t3,r7)=3, (t2,r4)=2 -> stream (2,1,5) then (7,3,3); (t2,r4) is not reported; max is (2,1,5); with CLEAR_ON_READ=1, the RAM is all zero after `done`.
3. Tie: (t0,r1)=9 and (t2,r0)=9 -> max = (1,0,9).
4. All 32 cells = 4, `peak_ready` toggled 1 cycle on / 3 off -> exactly 32 peaks in scan order, none lost or duplicated, `peak_*` stable while stalled, `done` only after the FIFO is empty.
5. `start` pulsed during SCAN -> ignored; the scan completes with 32 reads.
6. Assert `reset` at read 10 -> outputs 0 next edge, no further `rd_enable`/`clr_wren`; a following `start` performs a full 32-read scan.
